clk_enable_gen: RTL and testbench
=================================

// Module: clk_enable_gen
// PURPOSE
//   Parametrised multi-channel fractional clock-enable generator; successor to the fixed 5-output PLL wrapper.
//   From one reference clock it derives NUM_CH single-cycle enable strobes, each with average rate refclk*NUM/DEN.
//   Each channel's ratio is reprogrammable at runtime through a valid/ready port.
//   After reset or any reprogramming, locked drops, all channels restart phase-aligned, and locked reasserts after a settle period.
// PARAMETERS
//   NUM_CH      5                                  number of enable channels (1..16)
//   ACC_W       24                                 width of NUM, DEN and per-channel accumulator
//   LOCK_CYCLES 16                                 settle cycles with locked=0 before RUN (>=1)
//   DEF_NUM     {24'd3,24'd1,24'd6,24'd12,24'd24}  packed reset NUM per channel, ch0 in LSBs (48/24/12/10/6 MHz of 50)
//   DEF_DEN     {24'd25,24'd5,24'd25,24'd25,24'd25} packed reset DEN per channel, ch0 in LSBs
// PORTS
//   refclk     in   1                  sole clock; all logic on its rising edge
//   rst_n      in   1                  synchronous reset, active low
//   cfg_valid  in   1                  configuration request valid
//   cfg_ready  out  1                  configuration request may be accepted this cycle
//   cfg_ch     in   4                  target channel index
//   cfg_num    in   ACC_W              new numerator
//   cfg_den    in   ACC_W              new denominator
//   cfg_err    out  1                  one-cycle pulse: request rejected
//   ce         out  NUM_CH             per-channel enable strobes, registered
//   locked     out  1                  high while in RUN
// BEHAVIOUR
//   Reset (rst_n=0 at an edge):
//     - NUM/DEN regs <= DEF_NUM/DEF_DEN; accumulators <= 0.
//     - ce=0, locked=0, cfg_ready=0, cfg_err=0; FSM -> INIT.
//   FSM states:
//     - INIT: one cycle -> SETTLE (counter <= 0).
//     - SETTLE: counter increments; at counter==LOCK_CYCLES-1 -> RUN.
//     - RUN: steady state.
//     - APPLY: one cycle; writes NUM/DEN of cfg_ch, clears ALL accumulators, -> SETTLE (counter <= 0).
//   cfg_ready=1 in SETTLE and RUN only; 0 in INIT, APPLY and reset.
//   Accept = cfg_valid & cfg_ready; request fields are sampled on that edge.
//   Valid request (cfg_ch<NUM_CH, cfg_den!=0, cfg_num<=cfg_den):
//     - FSM -> APPLY; locked falls on the next cycle.
//     - An accept during SETTLE restarts the settle period.
//   Invalid request:
//     - cfg_err=1 for exactly the next cycle; no state or register change.
//     - cfg_ready stays 1; the FSM continues (SETTLE count is not disturbed).
//   locked=1 exactly when the FSM is in RUN (registered state decode).
//   Outside RUN: accumulators held at 0 and ce=0.
//   Per channel k, every RUN cycle:
//     - s = acc + NUM (ACC_W+1 bits, no overflow).
//     - If s >= DEN: acc <= s - DEN and carry=1; else acc <= s[ACC_W-1:0] and carry=0.
//     - ce[k] <= carry, so ce lags the carry by one cycle.
//   Counting RUN cycles n=1,2,...: ce[k] is high in cycle n+1 iff floor(n*NUM/DEN) > floor((n-1)*NUM/DEN).
//     - Average rate is exactly NUM/DEN; no cumulative drift.
//   Corner ratios: NUM=0 -> ce never asserts; NUM=DEN -> ce high every cycle from RUN cycle 2 onward.
//   All channels start from acc=0 on the same cycle, so the first strobes are phase-aligned.
//   On the RUN->APPLY transition, any ce already registered from the last RUN cycle is still output, then ce=0.
//   rst_n low in any state (including APPLY) -> reset values at that edge; a pending cfg write is discarded.
// TESTING
//   1. Reset, defaults:
//      - locked rises on the 1+LOCK_CYCLES-th edge after rst_n release.
//      - Over 250 RUN cycles, ce counts are {ch0:240, ch1:120, ch2:60, ch3:50, ch4:30} (+-1).
//   2. Program ch3 NUM=1, DEN=5 from RUN:
//      - cfg_ready low for one cycle; locked low for LOCK_CYCLES+1 cycles.
//      - ce[3] first high at RUN cycle 6, then every 5th cycle.
//   3. Invalid requests (ch=7; den=0; num=6/den=5):
//      - each gives a single-cycle cfg_err and no locked drop.
//      - Ratios are unchanged (ce counts as in test 1).
//   4. NUM=DEN=1 and NUM=0 on two channels:
//      - the first is high every cycle from RUN cycle 2; the second stays 0.
//   5. Back-to-back valid requests with cfg_valid held high:
//      - accepts occur only when cfg_ready=1; the last one wins.
//      - locked is held low until LOCK_CYCLES after the final APPLY.
//   6. rst_n pulsed low during APPLY and mid-SETTLE:
//      - outputs return to reset values on that edge; defaults are restored, not the programmed values.

Source files
------------

// File: rtl/clk_enable_gen_if.sv
// Configuration request port of clk_enable_gen: valid/ready handshake plus a
// one-cycle reject pulse.
interface clk_enable_gen_if #(
    parameter int ACC_W = 24
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [3:0]       cfg_ch;
    logic [ACC_W-1:0] cfg_num;
    logic [ACC_W-1:0] cfg_den;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_num, cfg_den,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_num, cfg_den,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator: each channel strobes at an
// average rate of refclk*NUM/DEN, with runtime reprogramming and a lock indicator.
module clk_enable_gen #(
    parameter int NUM_CH      = 5,
    parameter int ACC_W       = 24,
    parameter int LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] DEF_NUM = {24'd3, 24'd1, 24'd6, 24'd12, 24'd24},
    parameter logic [NUM_CH*ACC_W-1:0] DEF_DEN = {24'd25, 24'd5, 24'd25, 24'd25, 24'd25}
) (
    input  logic              refclk,
    input  logic              rst_n,
    clk_enable_gen_if.slave   cfg,
    output logic [NUM_CH-1:0] ce,
    output logic              locked
);
    localparam int         CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

    typedef enum logic [1:0] {ST_INIT, ST_SETTLE, ST_RUN, ST_APPLY} state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic             ready_r;
    logic             err_r;
    logic             accept;
    logic             req_ok;

    logic [3:0]       pend_ch;
    logic [ACC_W-1:0] pend_num;
    logic [ACC_W-1:0] pend_den;

    logic [ACC_W-1:0] num_r   [NUM_CH];
    logic [ACC_W-1:0] den_r   [NUM_CH];
    logic [ACC_W-1:0] acc     [NUM_CH];
    logic [ACC_W-1:0] acc_nxt [NUM_CH];
    logic [NUM_CH-1:0] carry;

    assign cfg.cfg_ready = ready_r;
    assign cfg.cfg_err   = err_r;

    assign accept = cfg.cfg_valid & ready_r;
    assign req_ok = ({1'b0, cfg.cfg_ch} < NUM_CH_L) && (cfg.cfg_den != '0) &&
                    (cfg.cfg_num <= cfg.cfg_den);

    // Control FSM; a rejected request only raises err and never disturbs the settle count.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            settle_cnt <= '0;
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
            locked     <= 1'b0;
        end else begin
            err_r <= 1'b0;
            case (state)
                ST_INIT: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                    ready_r    <= 1'b1;
                end
                ST_SETTLE, ST_RUN: begin
                    if (accept && req_ok) begin
                        state   <= ST_APPLY;
                        ready_r <= 1'b0;
                        locked  <= 1'b0;
                    end else begin
                        if (accept) begin
                            err_r <= 1'b1;
                        end
                        if (state == ST_SETTLE) begin
                            if (settle_cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                                state  <= ST_RUN;
                                locked <= 1'b1;
                            end else begin
                                settle_cnt <= settle_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_APPLY: begin
                    state      <= ST_SETTLE;
                    settle_cnt <= '0;
                    ready_r    <= 1'b1;
                end
                default: begin
                    state   <= ST_INIT;
                    ready_r <= 1'b0;
                    locked  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk) begin
        if (accept && req_ok) begin
            pend_ch  <= cfg.cfg_ch;
            pend_num <= cfg.cfg_num;
            pend_den <= cfg.cfg_den;
        end
    end

    // Phase accumulators: sum is one bit wider so acc+NUM never wraps.
    always_comb begin
        logic [ACC_W:0] sum;
        logic [ACC_W:0] diff;
        carry = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum      = {1'b0, acc[k]} + {1'b0, num_r[k]};
            diff     = sum - {1'b0, den_r[k]};
            carry[k] = (sum >= {1'b0, den_r[k]});
            acc_nxt[k] = carry[k] ? diff[ACC_W-1:0] : sum[ACC_W-1:0];
        end
    end

    // Registered strobe stage; everything outside RUN is forced to zero so all
    // channels restart phase-aligned.
    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                num_r[k] <= DEF_NUM[k*ACC_W +: ACC_W];
                den_r[k] <= DEF_DEN[k*ACC_W +: ACC_W];
                acc[k]   <= '0;
            end
            ce <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (state == ST_RUN) begin
                    acc[k] <= acc_nxt[k];
                    ce[k]  <= carry[k];
                end else begin
                    acc[k] <= '0;
                    ce[k]  <= 1'b0;
                end
                if ((state == ST_APPLY) && (pend_ch == 4'(k))) begin
                    num_r[k] <= pend_num;
                    den_r[k] <= pend_den;
                end
            end
        end
    end
endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: lock timing, default ratios, reprogramming,
// rejected requests, corner ratios, back-to-back requests and reset recovery.
module tb_clk_enable_gen;
    localparam int NUM_CH      = 5;
    localparam int ACC_W       = 24;
    localparam int LOCK_CYCLES = 16;

    logic              refclk = 1'b0;
    logic              rst_n  = 1'b0;
    logic [NUM_CH-1:0] ce;
    logic              locked;

    clk_enable_gen_if #(.ACC_W(ACC_W)) cfg_if ();

    clk_enable_gen #(
        .NUM_CH(NUM_CH),
        .ACC_W(ACC_W),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .refclk(refclk),
        .rst_n(rst_n),
        .cfg(cfg_if),
        .ce(ce),
        .locked(locked)
    );

    always #5 refclk = ~refclk;

    int n_chk = 0;
    int n_err = 0;
    int cnt [NUM_CH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic send(input int ch, input int num, input int den);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 4'(ch);
        cfg_if.cfg_num   = ACC_W'(num);
        cfg_if.cfg_den   = ACC_W'(den);
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    // Edges until locked is seen high (bounded).
    task automatic wait_lock(output int n);
        n = 0;
        while (!locked && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic count_win(input int len);
        for (int k = 0; k < NUM_CH; k++) cnt[k] = 0;
        repeat (len) begin
            tick();
            for (int k = 0; k < NUM_CH; k++) cnt[k] += int'(ce[k]);
        end
    endtask

    task automatic check_counts(input string tag, input int e0, input int e1, input int e2,
                                input int e3, input int e4);
        count_win(250);
        check({tag, "_ch0"}, cnt[0], e0);
        check({tag, "_ch1"}, cnt[1], e1);
        check({tag, "_ch2"}, cnt[2], e2);
        check({tag, "_ch3"}, cnt[3], e3);
        check({tag, "_ch4"}, cnt[4], e4);
    endtask

    // Called on RUN cycle 1; returns the RUN cycle numbers of the first two strobes.
    task automatic first_hits(input int ch, output int h1, output int h2);
        h1 = 0;
        h2 = 0;
        for (int rc = 1; rc <= 20; rc++) begin
            if (ce[ch]) begin
                if (h1 == 0) h1 = rc;
                else if (h2 == 0) h2 = rc;
            end
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_ready"}, 32'(cfg_if.cfg_ready), 0);
        check({tag, "_err"}, 32'(cfg_if.cfg_err), 0);
        check({tag, "_ce"}, 32'(ce), 0);
    endtask

    initial begin
        int n;
        int h1;
        int h2;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_num   = '0;
        cfg_if.cfg_den   = '0;

        // Reset and default ratios
        repeat (3) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        wait_lock(n);
        check("t1_lock_edges", n, 1 + LOCK_CYCLES);
        check("t1_ready_run", 32'(cfg_if.cfg_ready), 1);
        check_counts("t1", 240, 120, 60, 50, 30);

        // Program ch3 to 1/5 from RUN
        send(3, 1, 5);
        check("t2_ready_apply", 32'(cfg_if.cfg_ready), 0);
        check("t2_locked_apply", 32'(locked), 0);
        tick();
        check("t2_ready_settle", 32'(cfg_if.cfg_ready), 1);
        check("t2_ce_settle", 32'(ce), 0);
        wait_lock(n);
        check("t2_locked_low", n + 1, LOCK_CYCLES + 1);
        first_hits(3, h1, h2);
        check("t2_first_hit", h1, 6);
        check("t2_second_hit", h2, 11);

        // Rejected requests
        send(7, 1, 5);
        check("t3a_err", 32'(cfg_if.cfg_err), 1);
        check("t3a_locked", 32'(locked), 1);
        tick();
        check("t3a_err_clr", 32'(cfg_if.cfg_err), 0);
        send(1, 1, 0);
        check("t3b_err", 32'(cfg_if.cfg_err), 1);
        check("t3b_ready", 32'(cfg_if.cfg_ready), 1);
        tick();
        check("t3b_err_clr", 32'(cfg_if.cfg_err), 0);
        send(2, 6, 5);
        check("t3c_err", 32'(cfg_if.cfg_err), 1);
        tick();
        check("t3c_err_clr", 32'(cfg_if.cfg_err), 0);
        check("t3c_locked", 32'(locked), 1);
        check_counts("t3", 240, 120, 60, 50, 30);

        // Corner ratios: ch1 = 1/1, ch2 = 0/7
        send(1, 1, 1);
        wait_lock(n);
        send(2, 0, 7);
        wait_lock(n);
        check("t4_c1_ce1", 32'(ce[1]), 0);
        count_win(20);
        check("t4_full_rate", cnt[1], 20);
        check("t4_zero_rate", cnt[2], 0);

        // Back-to-back requests with valid held high; C (1/4) must win
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 4'd4;
        cfg_if.cfg_den   = ACC_W'(2);
        cfg_if.cfg_num   = ACC_W'(1);
        tick();
        check("t5_accA", 32'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_den = ACC_W'(3);
        tick();
        check("t5_noacc_apply", 32'(cfg_if.cfg_ready), 1);
        tick();
        check("t5_accB", 32'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_den = ACC_W'(4);
        tick();
        check("t5_noacc_apply2", 32'(cfg_if.cfg_ready), 1);
        check("t5_locked_mid", 32'(locked), 0);
        tick();
        check("t5_accC", 32'(cfg_if.cfg_ready), 0);
        cfg_if.cfg_valid = 1'b0;
        wait_lock(n);
        check("t5_locked_low", n, LOCK_CYCLES + 1);
        first_hits(4, h1, h2);
        check("t5_first_hit", h1, 5);
        check("t5_second_hit", h2, 9);

        // Reset during APPLY restores defaults
        send(0, 1, 2);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("t6a");
        rst_n = 1'b1;
        wait_lock(n);
        check("t6a_lock_edges", n, 1 + LOCK_CYCLES);
        check_counts("t6a", 240, 120, 60, 50, 30);

        // Reset mid-SETTLE
        send(2, 1, 1);
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        check_reset_outputs("t6b");
        rst_n = 1'b1;
        wait_lock(n);
        check("t6b_lock_edges", n, 1 + LOCK_CYCLES);
        check_counts("t6b", 240, 120, 60, 50, 30);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
